rv32im_lsu: RTL
===============

Name: rv32im_lsu

Overview:
- Load/store unit directly downstream of rv32im_exu.
- Consumes the EXU's LSU opcode, memory address (val_memaddr_o) and store data (val_memdatawr_o).
- Runs a single outstanding request/acknowledge transaction on the data-memory bus.
- Returns aligned, sign- or zero-extended load data, which the EXU receives on val_memdatard_i.
- Detects misaligned accesses and reports them without touching the bus.

Parameters:
- DATA_WIDTH, `API_DATA_WIDTH (32): data and address width.
- OPC_WIDTH, `LSU_OPCODE_WIDTH (4): width of the LSU opcode.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Used only with LSU_BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  EXU presents an operation.
- ready_o  out  1  LSU can accept an operation (high only in IDLE).
- lsu_opcode_i  in  OPC_WIDTH  operation, one of `LSU_OPCODE_*: NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8.
- addr_i  in  DATA_WIDTH  byte address from EXU.
- wdata_i  in  DATA_WIDTH  store data from EXU, right-justified.
- rdata_o  out  DATA_WIDTH  load result, extended; goes to EXU val_memdatard_i.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  completion with error; qualified by done_o.
- misalign_o  out  1  error cause is misalignment; qualified by done_o.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  DATA_WIDTH  word address, with bits [1:0] forced to 0.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  DATA_WIDTH  store data replicated into lanes.
- mem_ack_i  in  1  bus accepts/completes the transfer.
- mem_rdata_i  in  DATA_WIDTH  read word, valid when mem_ack_i is high.
- mem_err_i  in  1  bus error, qualified by mem_ack_i.

Behaviour:
- Reset: state=IDLE. ready_o=1 and every other output is 0, including rdata_o, mem_addr_o, mem_be_o and mem_wdata_o. A reset asserted in any state aborts the transaction, drops mem_req_o on the next edge and produces no done_o.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Accept happens when valid_i & ready_o & opcode!=NONE. Opcode NONE or any undefined code is ignored and the FSM stays in IDLE.
  - On accept, latch opcode and addr[1:0], and register the bus outputs.
  - Aligned access: go to REQ.
  - Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1, misalign=1. No bus request is made.
- REQ:
  - mem_req_o=1; address, be, we and wdata held stable.
  - On mem_ack_i=1: capture mem_rdata_i (loads) and mem_err_i, then go to RESP. mem_req_o falls on that same edge.
- RESP:
  - done_o=1 for exactly one cycle; rdata_o is valid, along with err_o and misalign_o.
  - Next state is IDLE. rdata_o holds its value until the next load completes.
- Latency: accept at cycle 0, mem_req_o high at cycle 1. Ack sampled in cycle k gives done_o in cycle k+1. Minimum is 2 cycles accept→done; misaligned is 1 cycle.
- Byte enables: SB gives 4'b0001<<addr[1:0]. SH gives 4'b0011<<addr[1:0]. SW gives 4'b1111. Loads use the same enables.
- Store data: SB replicates the byte into all 4 lanes; SH replicates the halfword into 2 lanes; SW passes the word through.
- Loads: select lane by addr[1:0], shift it down, then extend. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Bus error on a load: err_o=1, misalign_o=0, rdata_o=0.
- valid_i outside IDLE is ignored; the upstream side must hold it until ready_o is high.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, drop mem_req_o and go to RESP with err=1, misalign=0.
  - An ack in the same cycle as the timeout wins.
- Undefined: no counter; REQ waits indefinitely for ack.

Test Plan:
- LW at addr 0x100, ack on cycle 3 with rdata 0xDEADBEEF → mem_addr_o=0x100, be=1111, done_o on cycle 4, rdata_o=0xDEADBEEF, err_o=0.
- LB at 0x103 with mem_rdata 0x80FF1234 → be=1000, rdata_o=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SH at 0x206 with wdata 0x0000ABCD → mem_we_o=1, addr=0x204, be=1100, wdata=0xABCDABCD. SB at 0x201 with 0x5A → be=0010, wdata=0x5A5A5A5A.
- LW at 0x102 → no mem_req_o; done_o in the next cycle with err_o=1, misalign_o=1. Opcode NONE with valid_i=1 → state stays IDLE.
- LW at 0x0 with ack and mem_err_i=1 → done_o with err_o=1, misalign_o=0, rdata_o=0. Reset asserted while in REQ → mem_req_o=0 after the edge, no done_o, ready_o=1.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, and no ack → mem_req_o drops after 4 wait cycles, done_o with err_o=1.

Source files
------------

// File: rtl/rv32im_lsu.sv
// rv32im_lsu: single-outstanding load/store unit between rv32im_exu and the data-memory bus.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module rv32im_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPC_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [OPC_WIDTH-1:0]  lsu_opcode_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  misalign_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i
);
    localparam logic [OPC_WIDTH-1:0] OP_LB  = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OP_LH  = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OP_LW  = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OP_LBU = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OP_LHU = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OP_SB  = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OP_SH  = OPC_WIDTH'(7);
    localparam logic [OPC_WIDTH-1:0] OP_SW  = OPC_WIDTH'(8);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state_q, state_d;
    logic [OPC_WIDTH-1:0]  op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] lane, ext;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d, err_q, err_d, mis_q, mis_d;
    logic                  is_byte, is_half, is_word, is_store, legal, mis, accept;
`ifdef LSU_BUS_TIMEOUT_EN
    logic [7:0]            cnt_q, cnt_d;
`endif

    always_comb begin
        is_byte  = lsu_opcode_i == OP_LB || lsu_opcode_i == OP_LBU || lsu_opcode_i == OP_SB;
        is_half  = lsu_opcode_i == OP_LH || lsu_opcode_i == OP_LHU || lsu_opcode_i == OP_SH;
        is_word  = lsu_opcode_i == OP_LW || lsu_opcode_i == OP_SW;
        is_store = lsu_opcode_i == OP_SB || lsu_opcode_i == OP_SH || lsu_opcode_i == OP_SW;
        legal    = is_byte | is_half | is_word;
        mis      = (is_half & addr_i[0]) | (is_word & |addr_i[1:0]);
        accept   = valid_i & (state_q == IDLE) & legal;
        lane     = mem_rdata_i >> {off_q, 3'b000};
        ext      = op_q == OP_LB  ? {{24{lane[7]}}, lane[7:0]} :
                   op_q == OP_LBU ? {24'h0, lane[7:0]} :
                   op_q == OP_LH  ? {{16{lane[15]}}, lane[15:0]} :
                   op_q == OP_LHU ? {16'h0, lane[15:0]} : lane;
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        be_d     = be_q;
        we_d     = we_q;
        err_d    = err_q;
        mis_d    = mis_q;
`ifdef LSU_BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                op_d    = lsu_opcode_i;
                off_d   = addr_i[1:0];
                addr_d  = {addr_i[DATA_WIDTH-1:2], 2'b00};
                be_d    = is_byte ? 4'b0001 << addr_i[1:0] : is_half ? 4'b0011 << addr_i[1:0] : 4'b1111;
                wdata_d = is_byte ? {4{wdata_i[7:0]}} : is_half ? {2{wdata_i[15:0]}} : wdata_i;
                we_d    = is_store;
                err_d   = mis;
                mis_d   = mis;
                state_d = mis ? RESP : REQ;
`ifdef LSU_BUS_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
            REQ: if (mem_ack_i) begin
                state_d = RESP;
                err_d   = mem_err_i;
                mis_d   = 1'b0;
                rdata_d = we_q ? rdata_q : mem_err_i ? '0 : ext;
            end
`ifdef LSU_BUS_TIMEOUT_EN
            else if (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                state_d = RESP;
                err_d   = 1'b1;
                mis_d   = 1'b0;
            end else cnt_d = cnt_q + 8'd1;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
`ifdef LSU_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign ready_o     = state_q == IDLE;
    assign done_o      = state_q == RESP;
    assign err_o       = done_o & err_q;
    assign misalign_o  = done_o & mis_q;
    assign mem_req_o   = state_q == REQ;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
endmodule
